// File: rtl/pulse_meter_pkg.sv
// +---------------------------------------------------------------------------
// | pulse_meter_pkg : shared types and constants for the pulse period meter
// | Revision 1.0
// +---------------------------------------------------------------------------
`default_nettype none

package pulse_meter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    COUNT = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH    = 32;
  localparam int DEFAULT_AVG_LOG2 = 2;

  localparam logic [DEFAULT_WIDTH-1:0] COUNT_MAX = '1;

endpackage

`default_nettype wire

// File: rtl/pulse_period_meter_if.sv
// +---------------------------------------------------------------------------
// | pulse_period_meter_if : control/measurement bundle for pulse_period_meter
// | Revision 1.0
// +---------------------------------------------------------------------------
`default_nettype none

interface pulse_period_meter_if #(
  parameter int WIDTH = 32
) ();

  logic             enable;
  logic             in_pulse;
  logic [WIDTH-1:0] period;
  logic             period_valid;
  logic             measuring;
  logic             overflow;

  modport master (
    output enable,
    output in_pulse,
    input  period,
    input  period_valid,
    input  measuring,
    input  overflow
  );

  modport slave (
    input  enable,
    input  in_pulse,
    output period,
    output period_valid,
    output measuring,
    output overflow
  );

endinterface

`default_nettype wire

// File: rtl/rising_edge_detect.sv
// +---------------------------------------------------------------------------
// | rising_edge_detect : combinational rise = d & ~d_prev, d_prev registered
// | Revision 1.0
// +---------------------------------------------------------------------------
`default_nettype none

module rising_edge_detect (
  input  wire logic clock,
  input  wire logic reset,
  input  wire logic d,
  output logic      rise
);

  logic d_prev;

  always_ff @(posedge clock) begin
    if (reset) d_prev <= 1'b0;
    else       d_prev <= d;
  end

  assign rise = d & ~d_prev;

endmodule

`default_nettype wire

// File: rtl/pulse_period_meter.sv
// +---------------------------------------------------------------------------
// | pulse_period_meter : measures cycles between rising edges of in_pulse.
// | Optional averaging via PULSE_PERIOD_AVG_EN.          Revision 1.0
// +---------------------------------------------------------------------------
`default_nettype none

module pulse_period_meter
  import pulse_meter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
`ifdef PULSE_PERIOD_AVG_EN
  , parameter int AVG_LOG2 = DEFAULT_AVG_LOG2
`endif
) (
  input wire logic             clock,
  input wire logic             reset,
  pulse_period_meter_if.slave  bus
);

  localparam logic [WIDTH-1:0] COUNT_ALL_ONES = '1;
  localparam logic [WIDTH-1:0] COUNT_ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state, state_next;
  logic [WIDTH-1:0] count, count_next;
  logic [WIDTH-1:0] period_r, period_next;
  logic             valid_r, valid_next;
  logic             ovf_r, ovf_next;
  logic             rise;
  logic             report;
  logic             saturate;

`ifdef PULSE_PERIOD_AVG_EN
  logic [WIDTH+AVG_LOG2-1:0] acc, acc_next, acc_sum;
  logic [AVG_LOG2-1:0]       samples, samples_next;
`endif

  rising_edge_detect u_edge (
    .clock (clock),
    .reset (reset),
    .d     (bus.in_pulse),
    .rise  (rise)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      period_r <= '0;
      valid_r  <= 1'b0;
      ovf_r    <= 1'b0;
`ifdef PULSE_PERIOD_AVG_EN
      acc      <= '0;
      samples  <= '0;
`endif
    end else begin
      state    <= state_next;
      count    <= count_next;
      period_r <= period_next;
      valid_r  <= valid_next;
      ovf_r    <= ovf_next;
`ifdef PULSE_PERIOD_AVG_EN
      acc      <= acc_next;
      samples  <= samples_next;
`endif
    end
  end

  always_comb begin
    state_next  = state;
    count_next  = count;
    period_next = period_r;
    valid_next  = 1'b0;
    ovf_next    = ovf_r;
    report      = 1'b0;
    saturate    = 1'b0;

    // enable low wins over any edge seen in the same cycle
    if (!bus.enable) begin
      state_next = IDLE;
      count_next = '0;
    end else begin
      case (state)
        IDLE: begin
          count_next = '0;
          state_next = ARM;
        end
        ARM: begin
          if (rise) begin
            count_next = COUNT_ONE;
            state_next = COUNT;
          end
        end
        COUNT: begin
          if (rise) begin
            report     = 1'b1;
            count_next = COUNT_ONE;
          end else if (count == COUNT_ALL_ONES) begin
            saturate   = 1'b1;
            ovf_next   = 1'b1;
            state_next = ARM;
          end else begin
            count_next = count + COUNT_ONE;
          end
        end
        default: begin
          state_next = IDLE;
          count_next = '0;
        end
      endcase
    end

`ifdef PULSE_PERIOD_AVG_EN
    acc_sum      = acc + {{AVG_LOG2{1'b0}}, count};
    acc_next     = acc;
    samples_next = samples;
    if (!bus.enable || saturate) begin
      acc_next     = '0;
      samples_next = '0;
    end else if (report) begin
      if (samples == {AVG_LOG2{1'b1}}) begin
        period_next  = acc_sum[WIDTH+AVG_LOG2-1:AVG_LOG2];
        valid_next   = 1'b1;
        acc_next     = '0;
        samples_next = '0;
      end else begin
        acc_next     = acc_sum;
        samples_next = samples + {{(AVG_LOG2-1){1'b0}}, 1'b1};
      end
    end
`else
    if (report) begin
      period_next = count;
      valid_next  = 1'b1;
    end
`endif
  end

  assign bus.period       = period_r;
  assign bus.period_valid = valid_r;
  assign bus.measuring    = (state == COUNT);
  assign bus.overflow     = ovf_r;

endmodule

`default_nettype wire

// File: tb/tb_pulse_period_meter.sv
// Scoreboard bench for pulse_period_meter: timestamp-based reference model
// pushes expected reports; a negedge monitor pops and compares.
`default_nettype none

module tb_pulse_period_meter;

  localparam int W         = 8;
  localparam int COUNT_MAX = (1 << W) - 1;
  localparam int AVG_N     = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  pulse_period_meter_if #(.WIDTH(W)) bus ();

  pulse_period_meter #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  bit mon_on = 1'b0;

  // reference model state: mode 0=idle 1=armed 2=counting
  int      m_mode = 0;
  longint  m_cyc = 0;
  longint  m_t0 = 0;
  bit      m_prev = 1'b0;
  bit      m_ovf = 1'b0;
  bit      m_valid = 1'b0;
  longint  m_period = 0;
  longint  m_acc = 0;
  int      m_n = 0;
  longint  exp_q[$];

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, m_cyc);
    end
  endtask

  task automatic model_report(input longint p);
`ifdef PULSE_PERIOD_AVG_EN
    m_acc += p;
    m_n++;
    if (m_n == AVG_N) begin
      m_period = m_acc / AVG_N;
      exp_q.push_back(m_period);
      m_valid = 1'b1;
      m_acc = 0;
      m_n = 0;
    end
`else
    m_period = p;
    exp_q.push_back(p);
    m_valid = 1'b1;
`endif
  endtask

  // Model: a measurement starts at the arming edge's timestamp; each later
  // edge reports the elapsed cycle count and restarts the timestamp.
  initial begin
    forever begin
      bit r;
      @(posedge clock);
      m_cyc++;
      m_valid = 1'b0;
      r = bus.in_pulse && !m_prev;
      if (reset) begin
        m_mode = 0; m_ovf = 1'b0; m_period = 0; m_prev = 1'b0;
        m_acc = 0; m_n = 0;
      end else begin
        if (!bus.enable) begin
          m_mode = 0; m_acc = 0; m_n = 0;
        end else if (m_mode == 0) begin
          m_mode = 1;
        end else if (m_mode == 1) begin
          if (r) begin m_mode = 2; m_t0 = m_cyc; end
        end else begin
          if (r) begin
            model_report(m_cyc - m_t0);
            m_t0 = m_cyc;
          end else if (m_cyc - m_t0 == COUNT_MAX) begin
            m_ovf = 1'b1; m_mode = 1; m_acc = 0; m_n = 0;
          end
        end
        m_prev = bus.in_pulse;
      end
    end
  end

  // Monitor
  initial begin
    forever begin
      @(negedge clock);
      if (mon_on) begin
        if (bus.period_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_valid", 1, 0);
          end else begin
            chk("period_report", longint'(bus.period), exp_q.pop_front());
          end
        end
        chk("period_valid", longint'(bus.period_valid), longint'(m_valid));
        chk("period_hold", longint'(bus.period), m_period);
        chk("measuring", longint'(bus.measuring), longint'(m_mode == 2));
        chk("overflow", longint'(bus.overflow), longint'(m_ovf));
      end
    end
  end

  task automatic step(input logic r, input logic en, input logic p);
    @(negedge clock);
    reset = r;
    bus.enable = en;
    bus.in_pulse = p;
  endtask

  task automatic reset_check();
    @(posedge clock);
    #1;
    chk("rst_period", longint'(bus.period), 0);
    chk("rst_valid", longint'(bus.period_valid), 0);
    chk("rst_measuring", longint'(bus.measuring), 0);
    chk("rst_overflow", longint'(bus.overflow), 0);
  endtask

  task automatic pulse_train(input int gap, input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b1, 1'b1);
      for (int j = 1; j < gap; j++) step(1'b0, 1'b1, 1'b0);
    end
  endtask

  initial begin
    int dens[4] = '{1, 3, 20, 50};
    bus.enable = 1'b0;
    bus.in_pulse = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    mon_on = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    reset_check();

    // gaps of 5
    step(1'b0, 1'b1, 1'b0);
    pulse_train(5, 4);
    // held level counts as one edge, then edges 3 apart
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
    pulse_train(3, 3);
    // divider loaded with 99
    pulse_train(100, 5);
    // fastest period
    pulse_train(2, 8);
    // saturation then recovery
    for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 1'b0);
    pulse_train(7, 5);
    #1 chk("overflow_sticky", longint'(bus.overflow), 1);
    // reset mid-measurement
    pulse_train(6, 3);
    step(1'b1, 1'b1, 1'b0);
    reset_check();
    pulse_train(4, 6);
    // enable drop discards partial work; edge coincident with enable rise
    pulse_train(5, 2);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    pulse_train(5, 6);
    // averaging-style mixed periods
    pulse_train(4, 1); pulse_train(5, 1); pulse_train(6, 1); pulse_train(8, 1);
    pulse_train(4, 1);

    // randomized segments
    for (int s = 0; s < 40; s++) begin
      int d;
      int len;
      bit en;
      d = dens[$urandom_range(0, 3)];
      len = $urandom_range(50, 200);
      en = ($urandom_range(0, 7) != 0);
      for (int i = 0; i < len; i++) begin
        bit p;
        bit r;
        p = ($urandom_range(0, 99) < d);
        r = ($urandom_range(0, 399) == 0);
        step(r, en, p);
      end
    end

    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0);
    @(negedge clock);
    mon_on = 1'b0;
    chk("leftover_reports", longint'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pulse_period_meter.md
Name: pulse_period_meter

Overview:
- Receiving end of the rate-divider pulse interface: takes a pulse stream and measures the clock-cycle distance between successive rising edges.
- Reports each measured period with a one-cycle valid strobe.
- Used to check and calibrate divider outputs, and to recover timing from external tick sources, all in the single system clock domain.

Parameters:
- WIDTH, 32, width of the period counter and of the `period` output; matches the 32-bit divider count range.
- AVG_LOG2, 2, log2 of the averaging window; only used when PULSE_PERIOD_AVG_EN is defined.

Ports:
- clock  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  measurement enable; low forces IDLE.
- in_pulse  input  1  pulse stream under test; assumed synchronous to clock.
- period  output  WIDTH  last reported period in clock cycles.
- period_valid  output  1  one-cycle strobe; `period` is updated in the same cycle.
- measuring  output  1  high while in COUNT.
- overflow  output  1  sticky; counter saturated before an edge arrived.

Behaviour:
- Edge detect: edge = in_pulse & ~in_prev, where in_prev is in_pulse registered. A level held high counts as one edge. Edge detection is combinational from in_pulse.
- States: IDLE, ARM, COUNT.
  - IDLE: count=0. If enable, go to ARM next cycle.
  - ARM: wait for the first edge. On edge: count<=1, go to COUNT. No report is made.
  - COUNT, no edge: count<=count+1.
  - COUNT, edge: period<=count, period_valid<=1 in the next cycle, count<=1, stay in COUNT.
- Period definition: edges P cycles apart report P. Minimum reportable value is 2; a pulse high for one cycle and low for one cycle gives 2. A divider loaded with N yields P=N+1.
- Latency: period and period_valid change on the clock edge immediately after the cycle in which the closing edge is sampled.
- Saturation: in COUNT with count all-ones and no edge:
  - set overflow;
  - go to ARM; count is don't-care.
  - No period is reported; the next edge starts a fresh measurement.
- overflow is cleared only by reset.
- enable low in any state: next state IDLE, count<=0, period_valid<=0, period holds its value. enable low takes priority over a simultaneous edge.
- in_prev keeps tracking in_pulse in all states. An edge on the same cycle enable rises is missed, since IDLE→ARM takes one cycle.
- Reset values: period=0, period_valid=0, measuring=0, overflow=0, state=IDLE, in_prev=0, count=0.
- period_valid is never held for more than one cycle. A new edge may produce back-to-back reports.

Optional Feature:
- Macro: PULSE_PERIOD_AVG_EN.
- Defined:
  - Adds a WIDTH+AVG_LOG2-bit accumulator and an AVG_LOG2-bit sample counter.
  - Each completed period is added to the accumulator.
  - After 2^AVG_LOG2 periods: period<=accumulator>>AVG_LOG2 (truncating), period_valid pulses, accumulator and sample counter clear.
  - Overflow, enable low, or reset clear both the accumulator and the sample counter.
- Not defined: every completed period is reported directly, and no accumulator logic exists.

Decomposition:
- Package pulse_meter_pkg:
  - state enum {IDLE, ARM, COUNT};
  - default WIDTH and AVG_LOG2 constants;
  - COUNT_MAX (all-ones of WIDTH) constant.
- One natural sub-module: rising_edge_detect (clock, reset, d, edge). Reused by other pulse consumers in the design.

Test Plan:
- Reset mid-COUNT, after several edges → next cycle all outputs 0, state IDLE; first edge after enable only arms, with no valid.
- enable=1, edges at cycles 10, 15, 20 → period_valid at cycles 16 and 21, period=5 both times, measuring=1 from cycle 11.
- Drive in_pulse from a rate divider with cycle_amt=99 → steady period=100 every report, with no overflow.
- in_pulse held high for 8 cycles, then edges at 40 and 43 → the held level is one edge; report period=3 after edge 43.
- Use WIDTH=8 with no second edge for 300 cycles → overflow=1 with no valid. The next edge re-arms; following edges 7 apart report 7, and overflow stays 1.
- With PULSE_PERIOD_AVG_EN and AVG_LOG2=2, periods 4, 5, 6, 8 → single valid with period=5 (23>>2); enable drop after 2 periods discards the partial sum.
